round_counter: RTL and testbench

- Parametrised up/down counter for the AES round datapath; successor to the basic load/increment/decrement counter.
- Adds a bounded range 0..LIMIT with wrap-around or saturation, and a variable step.
- Adds an autonomous run mode that sweeps the full range up (encrypt) or down (decrypt) with busy/done handshake.
- Sits between the co-processor control FSM and key-schedule/round-key selection.

---
 rtl/round_counter_pkg.sv | 14 +
 rtl/mod_step_unit.sv | 56 +++++
 rtl/round_counter.sv | 120 ++++++++++++
 tb/tb_round_counter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_counter_pkg.sv
// Shared encodings and constants for the AES round counter and its step unit.
package round_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned AES_ROUNDS_128 = 10;

endpackage

// File: rtl/mod_step_unit.sv
// Combinational modulo-(LIMIT+1) step: next value and wrap flag for a manual
// increment or decrement of count by step, wrapping or saturating per WRAP.
module mod_step_unit #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LIMIT  = 10,
  parameter bit          WRAP   = 1'b1,
  parameter int unsigned STEP_W = 2
) (
  input  logic [WIDTH-1:0]  count_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              down_i,
  output logic [WIDTH-1:0]  next_o,
  output logic              wrap_o
);

  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(LIMIT + 1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;

  assign cnt_x  = {1'b0, count_i};
  assign step_x = (WIDTH+1)'(step_i);
  assign sum    = cnt_x + step_x;

  // One extra bit keeps count+step and count+MOD-step free of overflow.
  always_comb begin
    next_o = count_i;
    wrap_o = 1'b0;
    if (!down_i) begin
      if (sum > LIM) begin
        if (WRAP) begin
          next_o = WIDTH'(sum - MOD);
          wrap_o = 1'b1;
        end else begin
          next_o = WIDTH'(LIM);
        end
      end else begin
        next_o = WIDTH'(sum);
      end
    end else begin
      if (step_x > cnt_x) begin
        if (WRAP) begin
          next_o = WIDTH'(cnt_x + MOD - step_x);
          wrap_o = 1'b1;
        end else begin
          next_o = '0;
        end
      end else begin
        next_o = WIDTH'(cnt_x - step_x);
      end
    end
  end

endmodule

// File: rtl/round_counter.sv
// Bounded 0..LIMIT up/down round counter with manual stepping in IDLE and an
// autonomous full-range sweep in RUN, reporting busy and a done pulse.
module round_counter
  import round_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LIMIT  = AES_ROUNDS_128,
  parameter bit          WRAP   = 1'b1,
  parameter int unsigned STEP_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              increment,
  input  logic              decrement,
  input  logic [STEP_W-1:0] step,
  input  logic              start,
  input  logic              dir,
  input  logic              hold,
  output logic [WIDTH-1:0]  count,
  output logic              at_zero,
  output logic              at_max,
  output logic              wrapped,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             run_dir_q, run_dir_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic [WIDTH-1:0] run_next;
  logic [WIDTH-1:0] run_term;

  mod_step_unit #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT),
    .WRAP  (WRAP),
    .STEP_W(STEP_W)
  ) u_step (
    .count_i(count_q),
    .step_i (step),
    .down_i (decrement),
    .next_o (step_next),
    .wrap_o (step_wrap)
  );

  assign run_next = (run_dir_q == DIR_DOWN) ? (count_q - ONE) : (count_q + ONE);
  assign run_term = (run_dir_q == DIR_DOWN) ? '0 : LIM;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    run_dir_d = run_dir_q;
    done_d    = 1'b0;
    wrapped_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (load) begin
          count_d = (load_value > LIM) ? LIM : load_value;
        end else if (start) begin
          run_dir_d = dir;
          count_d   = (dir == DIR_DOWN) ? LIM : '0;
          state_d   = ST_RUN;
        end else if (increment ^ decrement) begin
          count_d   = step_next;
          wrapped_d = step_wrap;
        end
      end
      ST_RUN: begin
        if (clear) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (!hold) begin
          count_d = run_next;
          if (run_next == run_term) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      run_dir_q <= DIR_UP;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_dir_q <= run_dir_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign at_zero = (count_q == '0);
  assign at_max  = (count_q == LIM);
  assign wrapped = wrapped_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_round_counter.sv
// Self-checking bench: a wrapping and a saturating instance share stimulus and
// are compared against an arithmetic reference model plus directed sequences.
module tb_round_counter;

  localparam int W  = 4;
  localparam int L  = 10;
  localparam int SW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0, load = 1'b0, increment = 1'b0, decrement = 1'b0;
  logic          start = 1'b0, dir = 1'b0, hold = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [SW-1:0] step = '0;

  logic [W-1:0]  cnt_a, cnt_b;
  logic          az_a, am_a, wr_a, by_a, dn_a;
  logic          az_b, am_b, wr_b, by_b, dn_b;

  round_counter #(.WIDTH(W), .LIMIT(L), .WRAP(1'b1), .STEP_W(SW)) dut_wrap (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .increment(increment), .decrement(decrement), .step(step), .start(start),
    .dir(dir), .hold(hold), .count(cnt_a), .at_zero(az_a), .at_max(am_a),
    .wrapped(wr_a), .busy(by_a), .done(dn_a)
  );

  round_counter #(.WIDTH(W), .LIMIT(L), .WRAP(1'b0), .STEP_W(SW)) dut_sat (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .increment(increment), .decrement(decrement), .step(step), .start(start),
    .dir(dir), .hold(hold), .count(cnt_b), .at_zero(az_b), .at_max(am_b),
    .wrapped(wr_b), .busy(by_b), .done(dn_b)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: plain integer arithmetic on the counter value.
  typedef struct {
    int cnt;
    bit run;
    bit down;
    bit done;
    bit wrp;
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t mdl_next(mdl_t s, bit wrap_en);
    mdl_t n;
    int   t;
    n      = s;
    n.done = 1'b0;
    n.wrp  = 1'b0;
    if (!s.run) begin
      if (clear) n.cnt = 0;
      else if (load) n.cnt = (int'(load_value) > L) ? L : int'(load_value);
      else if (start) begin
        n.run  = 1'b1;
        n.down = dir;
        n.cnt  = dir ? L : 0;
      end else if (increment && !decrement) begin
        t = s.cnt + int'(step);
        if (t > L) begin
          if (wrap_en) begin n.cnt = t % (L + 1); n.wrp = 1'b1; end
          else n.cnt = L;
        end else n.cnt = t;
      end else if (decrement && !increment) begin
        t = s.cnt - int'(step);
        if (t < 0) begin
          if (wrap_en) begin n.cnt = t + (L + 1); n.wrp = 1'b1; end
          else n.cnt = 0;
        end else n.cnt = t;
      end
    end else begin
      if (clear) begin
        n.cnt = 0;
        n.run = 1'b0;
      end else if (!hold) begin
        n.cnt = s.down ? s.cnt - 1 : s.cnt + 1;
        if (n.cnt == (s.down ? 0 : L)) begin
          n.done = 1'b1;
          n.run  = 1'b0;
        end
      end
    end
    return n;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) m[i] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic chk_all();
    check("wrap_count",   int'(cnt_a), m[0].cnt);
    check("wrap_at_zero", int'(az_a),  int'(m[0].cnt == 0));
    check("wrap_at_max",  int'(am_a),  int'(m[0].cnt == L));
    check("wrap_wrapped", int'(wr_a),  int'(m[0].wrp));
    check("wrap_busy",    int'(by_a),  int'(m[0].run));
    check("wrap_done",    int'(dn_a),  int'(m[0].done));
    check("sat_count",    int'(cnt_b), m[1].cnt);
    check("sat_at_zero",  int'(az_b),  int'(m[1].cnt == 0));
    check("sat_at_max",   int'(am_b),  int'(m[1].cnt == L));
    check("sat_wrapped",  int'(wr_b),  int'(m[1].wrp));
    check("sat_busy",     int'(by_b),  int'(m[1].run));
    check("sat_done",     int'(dn_b),  int'(m[1].done));
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic cyc();
    m[0] = mdl_next(m[0], 1'b1);
    m[1] = mdl_next(m[1], 1'b0);
    @(posedge clock);
    #1;
    chk_all();
  endtask

  task automatic idle_in();
    clear = 1'b0; load = 1'b0; increment = 1'b0; decrement = 1'b0;
    start = 1'b0; dir = 1'b0; hold = 1'b0; load_value = '0; step = '0;
  endtask

  typedef struct {
    bit clr, ld;
    int lv;
    bit inc, dec;
    int stp;
    int c_wrap;
    bit w_wrap;
    int c_sat;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{0, 1, 7,  0, 0, 0,  7, 0,  7};
    tv[1] = '{0, 0, 0,  1, 0, 3, 10, 0, 10};
    tv[2] = '{0, 0, 0,  1, 0, 2,  1, 1, 10};
    tv[3] = '{0, 1, 1,  0, 0, 0,  1, 0,  1};
    tv[4] = '{0, 0, 0,  0, 1, 3,  9, 1,  0};
    tv[5] = '{0, 0, 0,  1, 1, 1,  9, 0,  0};
    tv[6] = '{0, 0, 0,  1, 0, 0,  9, 0,  0};
    tv[7] = '{0, 1, 13, 0, 0, 0, 10, 0, 10};
    tv[8] = '{1, 0, 0,  0, 0, 0,  0, 0,  0};
    tv[9] = '{0, 0, 0,  0, 1, 1, 10, 1,  0};

    mdl_reset();
    #12;
    chk_all();
    @(negedge clock);
    reset = 1'b1;

    // Manual stepping in IDLE, table driven.
    for (int i = 0; i < 10; i++) begin
      idle_in();
      clear = tv[i].clr; load = tv[i].ld; load_value = W'(tv[i].lv);
      increment = tv[i].inc; decrement = tv[i].dec; step = SW'(tv[i].stp);
      cyc();
      check("tbl_wrap_count", int'(cnt_a), tv[i].c_wrap);
      check("tbl_wrap_pulse", int'(wr_a),  int'(tv[i].w_wrap));
      check("tbl_sat_count",  int'(cnt_b), tv[i].c_sat);
      check("tbl_sat_pulse",  int'(wr_b),  0);
    end

    // Up sweep, then back-to-back down sweep started in the done cycle.
    idle_in(); start = 1'b1; dir = 1'b0;
    cyc();
    start = 1'b0;
    check("up_first", int'(cnt_a), 0);
    check("up_busy1", int'(by_a), 1);
    for (int k = 2; k <= 11; k++) begin
      cyc();
      check("up_count", int'(cnt_a), k - 1);
      check("up_busy",  int'(by_a), int'(k <= 10));
      check("up_done",  int'(dn_a), int'(k == 11));
    end
    start = 1'b1; dir = 1'b1;
    cyc();
    start = 1'b0; dir = 1'b0;
    check("dn_first", int'(cnt_a), 10);
    check("dn_busy1", int'(by_a), 1);
    for (int k = 2; k <= 11; k++) begin
      cyc();
      check("dn_count", int'(cnt_b), 11 - k);
      check("dn_done",  int'(dn_b), int'(k == 11));
    end

    // Down sweep with a 3-cycle hold at 6 and ignored load/increment.
    idle_in(); start = 1'b1; dir = 1'b1;
    cyc();
    start = 1'b0; dir = 1'b0;
    for (int k = 2; k <= 5; k++) cyc();
    check("hold_pre", int'(cnt_a), 6);
    hold = 1'b1; load = 1'b1; load_value = 4'd3; increment = 1'b1; step = 2'd2;
    for (int k = 6; k <= 8; k++) begin
      cyc();
      check("hold_count", int'(cnt_a), 6);
    end
    idle_in();
    for (int k = 9; k <= 14; k++) begin
      cyc();
      check("hold_after", int'(cnt_a), 14 - k);
      check("hold_done",  int'(dn_a), int'(k == 14));
      check("hold_busy",  int'(by_a), int'(k < 14));
    end

    // Abort with clear at 5, then clipped load.
    idle_in(); start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 2; k <= 6; k++) cyc();
    check("abort_pre", int'(cnt_a), 5);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("abort_count", int'(cnt_a), 0);
    check("abort_busy",  int'(by_a), 0);
    check("abort_done",  int'(dn_a), 0);
    load = 1'b1; load_value = 4'd13;
    cyc();
    load = 1'b0;
    check("clip_load", int'(cnt_a), 10);

    // Asynchronous reset mid-run at count 6.
    idle_in(); start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 2; k <= 7; k++) cyc();
    check("rst_pre", int'(cnt_a), 6);
    #2 reset = 1'b0;
    #1;
    mdl_reset();
    check("rst_count",   int'(cnt_a), 0);
    check("rst_busy",    int'(by_a), 0);
    check("rst_done",    int'(dn_a), 0);
    check("rst_at_zero", int'(az_a), 1);
    check("rst_at_max",  int'(am_a), 0);
    check("rst_sat_cnt", int'(cnt_b), 0);
    @(negedge clock);
    reset = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      clear      = ($urandom_range(0, 15) == 0);
      load       = ($urandom_range(0, 7) == 0);
      start      = ($urandom_range(0, 5) == 0);
      increment  = 1'($urandom);
      decrement  = 1'($urandom);
      dir        = 1'($urandom);
      hold       = ($urandom_range(0, 3) == 0);
      step       = SW'($urandom);
      load_value = W'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
